mtl2_sw_debounce: RTL
=====================

Name: mtl2_sw_debounce

Overview:
Conditions the raw DE0-Nano slide-switch / key pins before they reach the switch PIO input port (in_port). Per bit, it synchronises the asynchronous pin into clk, then debounces it with a saturating stability counter. It produces clean levels for the PIO plus one-cycle rise/fall pulses for painter-control logic. Sits directly upstream of the switch PIO, in the same clock domain.

Parameters:
WIDTH, 4, number of switch channels (matches PIO in_port width)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new level (1 ms at 50 MHz); legal range >= 2
SYNC_STAGES, 2, synchroniser flop depth; legal range >= 2

Ports:
clk  in  1  system clock (PIO clock)
reset_n  in  1  reset; synchronous, active-low
sw_raw  in  WIDTH  asynchronous switch pins
sw_stable  out  WIDTH  debounced levels; drives PIO in_port
sw_rise  out  WIDTH  one-cycle pulse per bit on accepted 0->1
sw_fall  out  WIDTH  one-cycle pulse per bit on accepted 1->0
sw_changed  out  1  OR-reduction of (sw_rise | sw_fall), registered with them

Behaviour:
- One clock; reset is synchronous and active-low: all state is sampled only on posedge clk, and reset_n==0 at an edge clears it.
- Reset values: synchroniser flops 0, counters 0, sw_stable 0, sw_rise 0, sw_fall 0, sw_changed 0.
- Reset asserted mid-debounce: the count is discarded and the output returns to 0 on that edge. No pulse is generated by reset itself.
- Synchroniser: sync[i] is sw_raw[i] delayed through SYNC_STAGES flops. No logic sits between the stages.
- Counter: per bit, width = clog2(DEBOUNCE_CYCLES).
  - If sync[i] == sw_stable[i], the counter clears to 0.
  - If they differ and the counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If they differ and the counter == DEBOUNCE_CYCLES-1, then at that edge: sw_stable[i] <= sync[i], counter <= 0, and the matching pulse bit <= 1.
- Pulses: sw_rise[i] / sw_fall[i] are high exactly one cycle, coincident with the first cycle the new sw_stable value is visible. They are 0 in every other cycle.
- Latency: a clean level change on sw_raw sampled at edge E appears on sw_stable after edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1. It is visible in the following cycle.
- Glitches: any mismatch run shorter than DEBOUNCE_CYCLES cycles (at sync) produces no output change. Any return to the stable value restarts the count from 0; there is no accumulation across bounces.
- Power-up with a switch held high: sw_stable[i] rises after the normal latency once reset deasserts, and sw_rise[i] pulses once. This is required behaviour; software ignores the first change.
- Channels are fully independent. Simultaneous acceptance on several bits produces several pulse bits in the same cycle, with sw_changed=1 for that single cycle.
- No wrap-around: the counter never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package mtl2_io_pkg: DEBOUNCE_CYCLES_DEFAULT, SIM_DEBOUNCE_CYCLES (=8), and a clog2-based counter-width function.
- Sub-module mtl2_debounce_bit (synchroniser + counter + stable/rise/fall for one bit), instantiated WIDTH times by a generate loop.
- The top level only replicates the sub-module and builds sw_changed.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, WIDTH=4):
1. Hold reset_n=0 with sw_raw=4'hF for 5 cycles -> all outputs 0 throughout reset. Release -> sw_stable=4'hF after 2+8-1 edges, and sw_rise=4'hF for exactly 1 cycle.
2. From stable 4'h0, set sw_raw[0]=1 cleanly -> sw_stable=4'h1 after 9 edges, sw_rise=4'h1 and sw_changed=1 for one cycle, sw_fall=0.
3. Bounce sw_raw[1] with high runs of 3, 5 and 7 cycles separated by 1-cycle lows, then hold high -> no change during the bounces. sw_stable[1] rises exactly 8 cycles after sync settles.
4. Apply a 7-cycle glitch 0->1->0 on sw_raw[2] -> sw_stable, sw_rise and sw_fall all stay 0.
5. Release sw_raw[0] and sw_raw[3] on the same edge from stable 4'h9 -> sw_stable=4'h0, sw_fall=4'h9 in the same single cycle, sw_changed=1 once.
6. Assert reset_n=0 for 1 cycle when counter[0]=5 during a pending 0->1 -> sw_stable stays 0. After release, acceptance takes a full 9 edges again and there is no early pulse.

Source files
------------

// File: rtl/mtl2_io_pkg.sv
// Shared constants and helpers for the switch/key input conditioning path.
// Imported by the per-bit debouncer and the top-level replicator.
package mtl2_io_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int SIM_DEBOUNCE_CYCLES     = 8;
  localparam int SYNC_STAGES_DEFAULT     = 2;

  // Counter only has to hold DEBOUNCE_CYCLES-1, so clog2 of the count is enough.
  function automatic int cntWidth(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/mtl2_debounce_bit.sv
// One switch channel: multi-flop synchroniser, saturating stability counter,
// and registered stable level with one-cycle rise/fall pulses.
module mtl2_debounce_bit
  import mtl2_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw_i,
  output logic sw_stable_o,
  output logic sw_rise_o,
  output logic sw_fall_o,
  output logic pulse_d_o
);

  localparam int             CW      = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   syncBit;

  assign syncBit = sync_q[SYNC_STAGES-1];
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], sw_raw_i};

  // Any agreement with the accepted level restarts the count, so bounces never accumulate.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (syncBit == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d    = '0;
      stable_d = syncBit;
      rise_d   = syncBit;
      fall_d   = ~syncBit;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign sw_stable_o = stable_q;
  assign sw_rise_o   = rise_q;
  assign sw_fall_o   = fall_q;
  assign pulse_d_o   = rise_d | fall_d;

endmodule

// File: rtl/mtl2_sw_debounce.sv
// Debounces the DE0-Nano switch/key pins ahead of the switch PIO, one
// independent channel per bit, plus a combined change strobe.
module mtl2_sw_debounce
  import mtl2_io_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  logic [WIDTH-1:0] pulseD;
  logic             changed_q, changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    mtl2_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) uBit (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw_i   (sw_raw[i]),
      .sw_stable_o(sw_stable[i]),
      .sw_rise_o  (sw_rise[i]),
      .sw_fall_o  (sw_fall[i]),
      .pulse_d_o  (pulseD[i])
    );
  end

  // Built from the pulses' next state so the strobe lands in the same cycle as them.
  assign changed_d = |pulseD;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign sw_changed = changed_q;

endmodule
